// File: rtl/iob_acc_pkg.sv
// Shared definitions for the iob_acc family: arithmetic mode encodings,
// channel slice offsets and saturation limits for any accumulator width.
`default_nettype none

package iob_acc_pkg;

  localparam logic ACC_WRAP = 1'b0;
  localparam logic ACC_SAT  = 1'b1;

  // Limits are built at a fixed wide width; callers keep the low ACC_W bits.
  localparam int LIM_W = 128;

  function automatic int ch_lo(input int ch, input int w);
    return ch * w;
  endfunction

  function automatic logic [LIM_W-1:0] lim_umax(input int w);
    return {LIM_W{1'b1}} >> (LIM_W - w);
  endfunction

  function automatic logic [LIM_W-1:0] lim_smax(input int w);
    return {LIM_W{1'b1}} >> (LIM_W - w + 1);
  endfunction

  function automatic logic [LIM_W-1:0] lim_smin(input int w);
    return {{(LIM_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_acc_ch.sv
// One accumulator channel: ld/en precedence, wrap or saturate on overflow,
// sticky overflow flag and integrate-and-dump beat counting.
`default_nettype none

module iob_acc_ch
  import iob_acc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sat_i,
  input  logic [LEN_W-1:0]  dump_len_i,
  input  logic              ld_i,
  input  logic [ACC_W-1:0]  ld_val_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] incr_i,
  input  logic              ovf_clr_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o,
  output logic              dump_valid_o,
  output logic [ACC_W-1:0]  dump_data_o
);

  localparam logic [LIM_W-1:0] UMAX_L = lim_umax(ACC_W);
  localparam logic [LIM_W-1:0] SMAX_L = lim_smax(ACC_W);
  localparam logic [LIM_W-1:0] SMIN_L = lim_smin(ACC_W);
  localparam logic [ACC_W-1:0] UMAX   = UMAX_L[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SMAX   = SMAX_L[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SMIN   = SMIN_L[ACC_W-1:0];

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             dv_q, dv_d;
  logic [ACC_W-1:0] dd_q, dd_d;

  logic [ACC_W-1:0] incr_ext;
  logic [ACC_W:0]   sum;
  logic             ovf_hit;
  logic [ACC_W-1:0] sat_val;
  logic [ACC_W-1:0] res;
  logic             dump_hit;

  generate
    if (ACC_W > DATA_W) begin : g_ext
      if (SIGNED != 0) begin : g_sext
        assign incr_ext = {{(ACC_W-DATA_W){incr_i[DATA_W-1]}}, incr_i};
      end else begin : g_zext
        assign incr_ext = {{(ACC_W-DATA_W){1'b0}}, incr_i};
      end
    end else begin : g_noext
      assign incr_ext = incr_i;
    end
  endgenerate

  assign sum = {1'b0, acc_q} + {1'b0, incr_ext};

  always_comb begin
    ovf_hit  = 1'b0;
    sat_val  = UMAX;
    if (SIGNED != 0) begin
      ovf_hit = (acc_q[ACC_W-1] == incr_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
      // Signed overflow direction follows the shared operand sign.
      sat_val = acc_q[ACC_W-1] ? SMIN : SMAX;
    end else begin
      ovf_hit = sum[ACC_W];
    end
    res      = (ovf_hit && (sat_i == ACC_SAT)) ? sat_val : sum[ACC_W-1:0];
    // ">=" lets a shortened dump_len take effect on the very next beat.
    dump_hit = (dump_len_i != '0) && (cnt_q >= (dump_len_i - LEN_W'(1)));
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~ovf_clr_i;
    dv_d  = 1'b0;
    dd_d  = dd_q;
    if (ld_i) begin
      acc_d = ld_val_i;
      cnt_d = '0;
    end else if (en_i) begin
      if (ovf_hit) begin
        ovf_d = 1'b1;
      end
      if (dump_hit) begin
        dd_d  = res;
        dv_d  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = res;
        cnt_d = cnt_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      dv_q  <= 1'b0;
      dd_q  <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      dv_q  <= dv_d;
      dd_q  <= dd_d;
    end
  end

  assign acc_o        = acc_q;
  assign ovf_o        = ovf_q;
  assign dump_valid_o = dv_q;
  assign dump_data_o  = dd_q;

endmodule

`default_nettype wire

// File: rtl/iob_acc_mc.sv
// Multi-channel accumulator: slices the packed buses and instantiates one
// independent iob_acc_ch per channel.
`default_nettype none

module iob_acc_mc
  import iob_acc_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sat_i,
  input  logic [LEN_W-1:0]         dump_len_i,
  input  logic [N_CH-1:0]          ld_i,
  input  logic [N_CH*ACC_W-1:0]    ld_val_i,
  input  logic [N_CH-1:0]          en_i,
  input  logic [N_CH*DATA_W-1:0]   incr_i,
  input  logic [N_CH-1:0]          ovf_clr_i,
  output logic [N_CH*ACC_W-1:0]    data_out_o,
  output logic [N_CH-1:0]          ovf_o,
  output logic [N_CH-1:0]          dump_valid_o,
  output logic [N_CH*ACC_W-1:0]    dump_data_o
);

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      localparam int LO_A = ch_lo(c, ACC_W);
      localparam int LO_D = ch_lo(c, DATA_W);

      iob_acc_ch #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W),
        .SIGNED (SIGNED)
      ) u_ch (
        .clk          (clk),
        .rst_n        (rst_n),
        .sat_i        (sat_i),
        .dump_len_i   (dump_len_i),
        .ld_i         (ld_i[c]),
        .ld_val_i     (ld_val_i[LO_A +: ACC_W]),
        .en_i         (en_i[c]),
        .incr_i       (incr_i[LO_D +: DATA_W]),
        .ovf_clr_i    (ovf_clr_i[c]),
        .acc_o        (data_out_o[LO_A +: ACC_W]),
        .ovf_o        (ovf_o[c]),
        .dump_valid_o (dump_valid_o[c]),
        .dump_data_o  (dump_data_o[LO_A +: ACC_W])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/iob_acc_mc.md
Name: iob_acc_mc

Overview:
Multi-channel, parametrised accumulator: successor to the single-channel iob_acc. N_CH independent channels, each with an ACC_W-bit accumulator fed by a DATA_W-bit increment, and runtime-selectable saturating or wrapping arithmetic. Each channel has signed/unsigned operation, a sticky overflow flag, and integrate-and-dump: after a programmable beat count it emits the result and restarts. Sits between sample producers (counters, DSP front-ends) and CSR/stream consumers.

Parameters:
N_CH, 4, number of independent channels (>=1)
DATA_W, 32, increment width per channel
ACC_W, 40, accumulator width per channel (ACC_W >= DATA_W)
LEN_W, 16, width of dump-length field
SIGNED, 0, 1 = two's-complement operands and result; 0 = unsigned

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
sat  in  1  1 = saturate on overflow, 0 = wrap; shared by all channels
dump_len  in  LEN_W  beats per dump; 0 disables dumping
ld  in  N_CH  per-channel synchronous load strobe
ld_val  in  N_CH*ACC_W  load values, channel c at [c*ACC_W +: ACC_W]
en  in  N_CH  per-channel accumulate strobe (one beat)
incr  in  N_CH*DATA_W  increments, channel c at [c*DATA_W +: DATA_W]
ovf_clr  in  N_CH  per-channel clear of sticky overflow flag
data_out  out  N_CH*ACC_W  running accumulator values (registered)
ovf  out  N_CH  sticky overflow flags
dump_valid  out  N_CH  one-cycle pulse: dump_data for that channel is new
dump_data  out  N_CH*ACC_W  last dumped result, held until next dump

Behaviour:
- Reset (rst_n low, async): data_out, ovf, dump_valid, dump_data, beat counters all 0. Accumulator reset value is fixed 0; non-zero starts use ld.
- Per-channel precedence each edge: ld > en > hold.
- ld: acc <= ld_val, beat counter <= 0, no overflow evaluation; en that cycle ignored.
- en: incr extended to ACC_W (sign-extend if SIGNED=1, zero-extend otherwise); sum computed at ACC_W+1 bits.
- Overflow: unsigned carry out of ACC_W; signed: operands same sign, result sign differs.
- On overflow: sat=1 -> clamp to 2^ACC_W-1 (unsigned), or max positive/most negative per direction (signed); sat=0 -> keep low ACC_W bits. ovf set in both modes.
- Latency: data_out reflects a beat on the edge after en is sampled (1 cycle).
- Dump: counter increments on every en beat. If dump_len != 0 and counter == dump_len-1 on an en beat: dump_data <= resolved sum, dump_valid <= 1 for exactly one cycle, acc <= 0, counter <= 0.
- dump_len = 1: every beat dumps; data_out stays 0.
- dump_len change mid-run is permitted: if counter >= new dump_len-1, the next beat dumps.
- ovf_clr: clears flag; an overflow in the same cycle wins (flag stays 1).
- Channels are fully independent; simultaneous activity on all channels is legal.
- Reset asserted mid-run: everything clears immediately (async); no partial dump is emitted.

Decomposition:
- Shared header/package iob_acc_pkg: mode encodings (ACC_WRAP=0, ACC_SAT=1), macros for channel slice offsets, saturation-limit constant functions (max/min for signed/unsigned at ACC_W).
- One sub-module iob_acc_ch: single channel (accumulator, beat counter, overflow/saturation logic, dump registers). Instantiated N_CH times in a generate loop.
- Top level does bus slicing only.

Test Plan:
- Reset then ch0 en 3 cycles, incr=5 -> data_out ch0 = 15 one cycle after last beat; ch1..3 = 0; ovf = 0.
- ACC_W=DATA_W=8, SIGNED=0: ld 250, en incr 10 with sat=1 -> 255, ovf=1. Repeat with sat=0 -> 4, ovf=1.
- ACC_W=DATA_W=8, SIGNED=1, sat=1: ld 0x82 (-126), incr 0xFB (-5) -> 0x80 (-128), ovf=1. ld 0x7E, incr 5 -> 0x7F.
- dump_len=4, beats incr 1,2,3,4 -> dump_valid pulses 1 cycle after 4th beat, dump_data=10, data_out=0; 5th beat incr 5 -> data_out 5, dump_data still 10.
- Same cycle: ld (ld_val=100) with en incr 7 -> data_out 100; ovf_clr coincident with a new overflow -> ovf remains 1; ovf_clr alone -> 0.
- Mid-run, drive rst_n low between edges -> all outputs 0 before the next edge; after release, first beat counts as beat 1 of a new dump window.
